ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage of the miniLA single-cycle core. It holds the architectural PC, fetches from IROM over a req/ack handshake that tolerates variable latency, and presents a stable instruction word plus `inst_valid` to the instruction decoder for the whole execute window. It commits the `npc` produced downstream when the core is not stalled, and it halts on a misaligned target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `IROM_AW`, default 14: IROM word-address width.
- `NOP_INST`, default 32'h0340_0000: `andi r0,r0,0`, presented on `inst` while no fetched instruction is valid.
- `cpu_clk`, in, 1: core clock. All state changes on its rising edge.
- `cpu_rst`, in, 1: asynchronous, active-high reset.
- `npc`, in, 32: next PC from the NPC stage. Sampled only on a commit edge.
- `stall`, in, 1: holds the current instruction in execute (for example, DRAM not ready).
- `irom_req`, out, 1: fetch request.
- `irom_addr`, out, IROM_AW: equals `pc[IROM_AW+1:2]`.
- `irom_ack`, in, 1: IROM data valid this cycle.
- `irom_rdata`, in, 32: IROM read data.
- `pc`, out, 32: address of the instruction being fetched or executed.
- `pc4`, out, 32: `pc + 32'd4`, combinational, wraps modulo 2^32.
- `inst`, out, 32: registered instruction word, fed to the decoder.
- `inst_valid`, out, 1: `inst` is valid and executing. Downstream gates all writes (RF, DRAM) with it.
- `fetch_err`, out, 1: sticky flag, set by a misaligned `npc`.
- `retired`, out, 32: count of committed instructions.

## Operation
- **States:** FETCH, EXEC, HALT. Reset state is FETCH.
- **FETCH:**
  - `irom_req`=1.
  - `irom_addr` is held stable until the ack.
  - On a cycle with `irom_ack`=1: `inst`<=`irom_rdata`, and the next state is EXEC.
  - With no ack, the block stays in FETCH indefinitely; there is no timeout.
- **EXEC:**
  - `inst_valid`=1 and `irom_req`=0. `inst` and `pc` are held.
  - Commit is defined as EXEC with `stall`=0.
  - Commit with `npc[1:0]==2'b00`:
    - `pc`<=`npc` and `retired`<=`retired`+1, wrapping at 2^32.
    - `inst`<=`NOP_INST`.
    - Next state is FETCH.
  - Commit with `npc[1:0]!=2'b00`:
    - `retired` still increments, because the current instruction completed.
    - `pc` is unchanged and `fetch_err`<=1.
    - Next state is HALT.
  - EXEC with `stall`=1: all state is held. Stall may last any number of cycles.
- **HALT:** terminal state.
  - `irom_req`=0, `inst_valid`=0, `inst`=`NOP_INST`.
  - Only reset exits HALT.
- **Ignored inputs:**
  - `irom_ack` is ignored outside FETCH. A late ack from a request that reset abandoned has no effect.
  - `stall` is ignored outside EXEC.
  - `npc` equal to `pc` (self-loop) is legal and refetches the same address.
- **Reset values (immediate, asynchronous):**
  - state=FETCH, `pc`=`RESET_PC`, `inst`=`NOP_INST`.
  - `inst_valid`=0, `fetch_err`=0, `retired`=0.
  - `irom_req` is 1 as soon as reset deasserts; it is combinational from state.
- **Reset mid-operation:** any FETCH or EXEC in progress is abandoned and no commit occurs. The IROM must tolerate a dropped request.

## Timing
- `irom_req`, `irom_addr`, `inst_valid` and `pc4` are combinational from registered state. No input-to-output combinational path exists except through the IROM itself.
- **Minimum instruction period is 2 cycles:** FETCH with same-cycle ack, then EXEC with `stall`=0.
- **With IROM latency L cycles (ack L cycles after `irom_req` first rises) and S stall cycles:** period = L+2+S.
- **Cycle 0** is the first rising edge after `cpu_rst` falls; FETCH of `RESET_PC` is already active at that edge. With ack in cycle 0, `inst_valid` is 1 in cycle 1.
- **Commit edge:** `pc`, `retired` and state update on the same edge. The next `irom_addr` reflects the new `pc` in the following cycle.
- **`fetch_err`** rises on the commit edge that detects the misalignment and remains 1.

## Test plan
- **Zero-latency run:** reset; IROM acks every request immediately, with rdata = word address; `npc` = `pc4`. Required:
  - `pc` sequence 0,4,8,12.
  - `inst_valid` toggles 0,1,0,1.
  - `retired`=3 after 6 cycles following cycle 0.
- **Latency 3 with stall 2:** required:
  - 7 cycles per instruction.
  - `inst` and `pc` unchanged throughout EXEC and stall.
  - `irom_addr` stable while `irom_req`=1.
- **Branch to 32'h0000_0100:** the commit loads `pc`=0x100, and the next `irom_addr`=0x40.
- **Misaligned `npc`=32'h0000_0102:** required:
  - `fetch_err`=1, state=HALT.
  - `pc` stays at the old value.
  - `irom_req`=0, `inst`=0x0340_0000.
  - `retired` incremented once.
  - Further `irom_ack`/`stall` activity has no effect.
- **Reset mid-WAIT:** assert `cpu_rst` during FETCH with the ack pending, then deliver a stray ack after deassert while the new FETCH runs. Required:
  - All outputs reach their reset values immediately.
  - The stray ack is accepted only as data for the `RESET_PC` fetch.
  - `retired`=0.
- **Counter wrap:** force `retired` to 32'hFFFF_FFFF and commit once; `retired`=0 and `pc` advances normally.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Bundle of the fetch-stage signals: NPC/stall from downstream, the IROM
// req/ack port, and the PC/instruction outputs toward decode.
//
// IROM handshake: irom_req is high for every cycle the fetch stage is
// waiting for an instruction, and irom_addr is held constant while it is
// high. The IROM raises irom_ack for exactly the cycle in which irom_rdata
// is valid; that cycle completes the transfer. There is no back-pressure on
// the ack side, and an ack seen while irom_req is low is discarded.
interface ifetch_unit_if #(
  parameter int IROM_AW = 14
);
  logic [31:0]        npc;
  logic               stall;
  logic               irom_req;
  logic [IROM_AW-1:0] irom_addr;
  logic               irom_ack;
  logic [31:0]        irom_rdata;
  logic [31:0]        pc;
  logic [31:0]        pc4;
  logic [31:0]        inst;
  logic               inst_valid;
  logic               fetch_err;
  logic [31:0]        retired;
  logic [1:0]         fsm_state;

  // Fetch unit side.
  modport master (
    input  npc, stall, irom_ack, irom_rdata,
    output irom_req, irom_addr, pc, pc4, inst, inst_valid,
           fetch_err, retired, fsm_state
  );

  // Core/IROM environment side.
  modport slave (
    output npc, stall, irom_ack, irom_rdata,
    input  irom_req, irom_addr, pc, pc4, inst, inst_valid,
           fetch_err, retired, fsm_state
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one word per
// instruction from IROM, holds it for the execute window, commits npc when
// not stalled and halts permanently on a misaligned target.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IROM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic   cpu_clk,
  input  logic   cpu_rst,
  ifetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] retired_q;
  logic        fetch_err_q;

  logic commit;
  logic npc_aligned;
  logic take_ack;

  assign commit      = (state_q == S_EXEC) && !bus.stall;
  assign npc_aligned = (bus.npc[1:0] == 2'b00);
  assign take_ack    = (state_q == S_FETCH) && bus.irom_ack;

  // State register; reset lands in FETCH so the first request is immediate.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Next-state logic: ack ends FETCH, commit ends EXEC, HALT is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (bus.irom_ack) state_d = S_EXEC;
      S_EXEC:  if (!bus.stall)   state_d = npc_aligned ? S_FETCH : S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Moore outputs decoded purely from the registered state.
  always_comb begin
    bus.irom_req   = 1'b0;
    bus.inst_valid = 1'b0;
    case (state_q)
      S_FETCH: bus.irom_req   = 1'b1;
      S_EXEC:  bus.inst_valid = 1'b1;
      default: ;
    endcase
  end

  // PC / instruction / counters. A misaligned commit still retires the
  // current instruction but leaves pc pointing at it for post-mortem.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      retired_q   <= 32'd0;
      fetch_err_q <= 1'b0;
    end else begin
      if (take_ack) inst_q <= bus.irom_rdata;
      if (commit) begin
        retired_q <= retired_q + 32'd1;
        inst_q    <= NOP_INST;
        if (npc_aligned) pc_q        <= bus.npc;
        else             fetch_err_q <= 1'b1;
      end
    end
  end

  assign bus.irom_addr = pc_q[IROM_AW+1:2];
  assign bus.pc        = pc_q;
  assign bus.pc4       = pc_q + 32'd4;
  assign bus.inst      = inst_q;
  assign bus.fetch_err = fetch_err_q;
  assign bus.retired   = retired_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: table of instructions (latency, stall, npc) plus
// hand-written halt, reset-abandon and counter-wrap sequences. Fetched
// words are predicted from the bench's own PC table into exp_q and popped
// when the DUT enters EXEC.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0340_0000;
  localparam logic [1:0]  ST_FETCH = 2'd0;
  localparam logic [1:0]  ST_EXEC  = 2'd1;
  localparam logic [1:0]  ST_HALT  = 2'd2;

  logic cpu_clk;
  logic cpu_rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_q[$];

  ifetch_unit_if #(.IROM_AW(14)) bus ();

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .IROM_AW (14),
    .NOP_INST(NOP)
  ) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .bus    (bus)
  );

  // Clock and cycle counter.
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;
  initial cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct {
    int          lat;
    int          stl;
    logic [31:0] npc;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    return 32'h1300_0000 | {18'b0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    #1;
    check("rst pc", bus.pc, 32'h0);
    check("rst inst", bus.inst, NOP);
    check("rst valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst err", {31'b0, bus.fetch_err}, 32'd0);
    check("rst retired", bus.retired, 32'd0);
    check("rst state", {30'b0, bus.fsm_state}, {30'b0, ST_FETCH});
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    #1;
    check("rst req", {31'b0, bus.irom_req}, 32'd1);
  endtask

  // Pop the scoreboard and compare against the DUT instruction word.
  task automatic sb_check(input string tag, output logic [31:0] got);
    got = 32'hx;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s sb_empty actual=%h required=none", tag, bus.inst);
    end else begin
      got = exp_q.pop_front();
      if (bus.inst !== got) begin
        n_fail++;
        $display("FAIL %s inst actual=%h required=%h", tag, bus.inst, got);
      end
    end
  endtask

  // One instruction from FETCH entry to the edge after its commit.
  // Called right after a falling edge with the DUT in FETCH.
  task automatic do_instr(input int lat, input int stl, input logic [31:0] npc_val,
                          input logic [31:0] exp_pc, input string tag);
    int          c0;
    logic [31:0] held;
    c0 = cyc;
    check({tag, " req"}, {31'b0, bus.irom_req}, 32'd1);
    check({tag, " pc"}, bus.pc, exp_pc);
    check({tag, " pc4"}, bus.pc4, exp_pc + 32'd4);
    check({tag, " addr"}, {18'b0, bus.irom_addr}, {18'b0, exp_pc[15:2]});
    for (int k = 0; k < lat; k++) begin
      bus.irom_ack   = 1'b0;
      bus.irom_rdata = $urandom;
      @(negedge cpu_clk);
      check({tag, " wait addr"}, {18'b0, bus.irom_addr}, {18'b0, exp_pc[15:2]});
      check({tag, " wait req"}, {31'b0, bus.irom_req}, 32'd1);
      check({tag, " wait valid"}, {31'b0, bus.inst_valid}, 32'd0);
    end
    bus.irom_ack   = 1'b1;
    bus.irom_rdata = rom_word(bus.irom_addr);
    exp_q.push_back(rom_word(exp_pc[15:2]));
    @(negedge cpu_clk);
    bus.irom_ack   = 1'b0;
    bus.irom_rdata = $urandom;
    check({tag, " exec valid"}, {31'b0, bus.inst_valid}, 32'd1);
    check({tag, " exec req"}, {31'b0, bus.irom_req}, 32'd0);
    sb_check(tag, held);
    for (int k = 0; k < stl; k++) begin
      bus.stall = 1'b1;
      bus.npc   = $urandom;
      @(negedge cpu_clk);
      check({tag, " stall inst"}, bus.inst, held);
      check({tag, " stall pc"}, bus.pc, exp_pc);
      check({tag, " stall valid"}, {31'b0, bus.inst_valid}, 32'd1);
    end
    bus.stall = 1'b0;
    bus.npc   = npc_val;
    @(negedge cpu_clk);
    check({tag, " period"}, cyc - c0, lat + 2 + stl);
  endtask

  initial begin
    logic [31:0] got;
    n_tests        = 0;
    n_fail         = 0;
    cpu_rst        = 1'b0;
    bus.npc        = 32'h0;
    bus.stall      = 1'b0;
    bus.irom_ack   = 1'b0;
    bus.irom_rdata = 32'h0;

    vecs[0] = '{lat: 0, stl: 0, npc: 32'h0000_0004, exp_pc: 32'h0000_0000, exp_ret: 32'd1};
    vecs[1] = '{lat: 0, stl: 0, npc: 32'h0000_0008, exp_pc: 32'h0000_0004, exp_ret: 32'd2};
    vecs[2] = '{lat: 0, stl: 0, npc: 32'h0000_000C, exp_pc: 32'h0000_0008, exp_ret: 32'd3};
    vecs[3] = '{lat: 3, stl: 2, npc: 32'h0000_0010, exp_pc: 32'h0000_000C, exp_ret: 32'd4};
    vecs[4] = '{lat: 1, stl: 0, npc: 32'h0000_0100, exp_pc: 32'h0000_0010, exp_ret: 32'd5};
    vecs[5] = '{lat: 2, stl: 1, npc: 32'h0000_0100, exp_pc: 32'h0000_0100, exp_ret: 32'd6};
    vecs[6] = '{lat: 0, stl: 3, npc: 32'h0000_0104, exp_pc: 32'h0000_0100, exp_ret: 32'd7};

    #3;
    do_reset();

    // Table: zero-latency run, latency/stall, branch, self-loop.
    for (int i = 0; i < 7; i++) begin
      do_instr(vecs[i].lat, vecs[i].stl, vecs[i].npc, vecs[i].exp_pc, $sformatf("v%0d", i));
      check($sformatf("v%0d retired", i), bus.retired, vecs[i].exp_ret);
      check($sformatf("v%0d new pc", i), bus.pc, vecs[i].npc);
      check($sformatf("v%0d new addr", i), {18'b0, bus.irom_addr}, {18'b0, vecs[i].npc[15:2]});
      check($sformatf("v%0d nop", i), bus.inst, NOP);
      check($sformatf("v%0d valid", i), {31'b0, bus.inst_valid}, 32'd0);
      check($sformatf("v%0d state", i), {30'b0, bus.fsm_state}, {30'b0, ST_FETCH});
    end

    // Misaligned target halts with pc frozen.
    do_instr(0, 1, 32'h0000_0102, 32'h0000_0104, "mis");
    for (int k = 0; k < 5; k++) begin
      check("halt err", {31'b0, bus.fetch_err}, 32'd1);
      check("halt state", {30'b0, bus.fsm_state}, {30'b0, ST_HALT});
      check("halt pc", bus.pc, 32'h0000_0104);
      check("halt req", {31'b0, bus.irom_req}, 32'd0);
      check("halt valid", {31'b0, bus.inst_valid}, 32'd0);
      check("halt inst", bus.inst, NOP);
      check("halt retired", bus.retired, 32'd8);
      bus.irom_ack   = 1'($urandom_range(0, 1));
      bus.stall      = 1'($urandom_range(0, 1));
      bus.irom_rdata = $urandom;
      bus.npc        = {$urandom} & 32'hFFFF_FFFC;
      @(negedge cpu_clk);
    end
    bus.irom_ack = 1'b0;
    bus.stall    = 1'b0;

    // Reset out of HALT, then abandon a pending fetch with reset.
    do_reset();
    do_instr(0, 0, 32'h0000_0004, 32'h0000_0000, "pre");
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    check("pend pc", bus.pc, 32'h0000_0004);
    check("pend req", {31'b0, bus.irom_req}, 32'd1);
    #2;
    cpu_rst = 1'b1;
    #1;
    check("mid pc", bus.pc, 32'h0);
    check("mid retired", bus.retired, 32'd0);
    check("mid valid", {31'b0, bus.inst_valid}, 32'd0);
    check("mid inst", bus.inst, NOP);
    @(negedge cpu_clk);
    cpu_rst        = 1'b0;
    bus.irom_ack   = 1'b1;
    bus.irom_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge cpu_clk);
    bus.irom_ack = 1'b0;
    check("stray valid", {31'b0, bus.inst_valid}, 32'd1);
    check("stray pc", bus.pc, 32'h0);
    check("stray retired", bus.retired, 32'd0);
    sb_check("stray", got);

    // Counter wrap: preset retired while stalled in EXEC, then commit.
    bus.stall = 1'b1;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    @(negedge cpu_clk);
    check("wrap pre", bus.retired, 32'hFFFF_FFFF);
    check("wrap hold inst", bus.inst, 32'hDEAD_BEEF);
    bus.stall = 1'b0;
    bus.npc   = 32'h0000_0004;
    @(negedge cpu_clk);
    check("wrap retired", bus.retired, 32'd0);
    check("wrap pc", bus.pc, 32'h0000_0004);
    check("wrap state", {30'b0, bus.fsm_state}, {30'b0, ST_FETCH});
    check("wrap err", {31'b0, bus.fetch_err}, 32'd0);
    check("sb drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
